// File: rtl/onewire_pkg.sv
// onewire_pkg: shared commands, scratchpad constants and FSM states
// for the 1-Wire temperature path (master and slave).
package onewire_pkg;

    localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] CMD_CONVERT  = 8'h44;
    localparam logic [7:0] CMD_READ_SP  = 8'hBE;

    localparam logic [7:0] SP_TH   = 8'h4B;
    localparam logic [7:0] SP_TL   = 8'h46;
    localparam logic [7:0] SP_CFG  = 8'h7F;
    localparam logic [7:0] SP_RSV0 = 8'hFF;
    localparam logic [7:0] SP_RSV1 = 8'h0C;
    localparam logic [7:0] SP_RSV2 = 8'h10;

    localparam logic [7:0]  CRC8_POLY = 8'h8C;
    localparam logic [15:0] TEMP_POR  = 16'h0550;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRES_WAIT,
        S_PRES_DRIVE,
        S_ROM_RX,
        S_FUNC_RX,
        S_CONV_RD,
        S_TX
    } state_t;

    function automatic logic [7:0] sp_byte(
        input logic [15:0] temp,
        input logic [3:0]  idx
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = temp[7:0];
            4'd1:    b = temp[15:8];
            4'd2:    b = SP_TH;
            4'd3:    b = SP_TL;
            4'd4:    b = SP_CFG;
            4'd5:    b = SP_RSV0;
            4'd6:    b = SP_RSV1;
            4'd7:    b = SP_RSV2;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/onewire_crc8.sv
// onewire_crc8: bit-serial Dallas CRC8 (reflected 0x8C, init 0).
// Shared by the slave (generation) and the master (checking).
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 8'h00;
        end else if (en_i) begin
            crc_d = (crc_q >> 1) ^ ((crc_q[0] ^ bit_i) ? CRC8_POLY : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/onewire_temp_slave.sv
// onewire_temp_slave: single DS18B20-style responder on the shared dq line.
// Handles reset/presence, Skip ROM, Convert T and Read Scratchpad.
module onewire_temp_slave
    import onewire_pkg::*;
#(
    parameter int CLK_PER_US   = 50,
    parameter int CONV_US      = 750000,
    parameter int RST_MIN_US   = 480,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_LEN_US  = 120,
    parameter int SAMPLE_US    = 30,
    parameter int TX0_US       = 45
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dq_in,
    output logic        dq_oe,
    input  logic [15:0] temp_in,
    output logic        conv_busy,
    output logic        cmd_err
);

    localparam int PSW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int TW  = 10;
    localparam int LW  = 12;

    logic           dq_s1_q, dq_s2_q, dq_p_q;
    logic [PSW-1:0] psc_q;
    logic [LW-1:0]  low_q;
    logic           tick, fall, rise, rst_det, slot_st, slot_edge;

    state_t         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           slot_q, slot_d;
    logic           txb_q, txb_d;
    logic [6:0]     bit_q, bit_d;
    logic [7:0]     sh_q, sh_d;
    logic           dq_oe_q, dq_oe_d;
    logic           cmd_err_q, cmd_err_d;

    logic           conv_start;
    logic           busy_q;
    logic [19:0]    conv_q;
    logic [15:0]    temp_q;

    logic           crc_clr, crc_en, tx_cur, nb;
    logic [7:0]     crc, sp_cur, rx_byte;

    assign tick    = (psc_q == PSW'(CLK_PER_US - 1));
    assign fall    = dq_p_q & ~dq_s2_q;
    assign rise    = ~dq_p_q & dq_s2_q;
    assign rst_det = rise && (low_q >= LW'(RST_MIN_US));
    assign slot_st = (state_q == S_ROM_RX) || (state_q == S_FUNC_RX) ||
                     (state_q == S_CONV_RD) || (state_q == S_TX);
    // Edges caused by our own pull-down are not slots.
    assign slot_edge = fall & ~dq_oe_q & slot_st;

    assign rx_byte = {dq_s2_q, sh_q[7:1]};
    assign sp_cur  = (bit_q[6:3] == 4'd8) ? crc : sp_byte(temp_q, bit_q[6:3]);
    assign tx_cur  = sp_cur[bit_q[2:0]];
    assign nb      = (state_q == S_CONV_RD) ? ~busy_q : tx_cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dq_s1_q <= 1'b1;
            dq_s2_q <= 1'b1;
            dq_p_q  <= 1'b1;
            psc_q   <= '0;
            low_q   <= '0;
        end else begin
            dq_s1_q <= dq_in;
            dq_s2_q <= dq_s1_q;
            dq_p_q  <= dq_s2_q;
            psc_q   <= tick ? '0 : psc_q + 1'b1;
            if (dq_s2_q) begin
                low_q <= '0;
            end else if (tick && !(&low_q)) begin
                low_q <= low_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = (tick && !(&tmr_q)) ? tmr_q + 1'b1 : tmr_q;
        slot_d     = slot_q;
        txb_d      = txb_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        dq_oe_d    = 1'b0;
        cmd_err_d  = 1'b0;
        conv_start = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        if (rst_det) begin
            state_d = S_PRES_WAIT;
            tmr_d   = '0;
            slot_d  = 1'b0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_PRES_WAIT: begin
                    if (tmr_q == TW'(PRES_WAIT_US)) begin
                        state_d = S_PRES_DRIVE;
                        tmr_d   = '0;
                        dq_oe_d = 1'b1;
                    end
                end
                S_PRES_DRIVE: begin
                    if (tmr_q == TW'(PRES_LEN_US)) begin
                        state_d = S_ROM_RX;
                        slot_d  = 1'b0;
                        bit_d   = '0;
                    end else begin
                        dq_oe_d = 1'b1;
                    end
                end
                S_ROM_RX, S_FUNC_RX: begin
                    if (slot_edge) begin
                        slot_d = 1'b1;
                        tmr_d  = '0;
                    end else if (slot_q && tmr_q == TW'(SAMPLE_US)) begin
                        slot_d = 1'b0;
                        sh_d   = rx_byte;
                        bit_d  = bit_q + 7'd1;
                        if (bit_q == 7'd7) begin
                            bit_d = '0;
                            if (state_q == S_ROM_RX) begin
                                if (rx_byte == CMD_SKIP_ROM) begin
                                    state_d = S_FUNC_RX;
                                end else begin
                                    cmd_err_d = 1'b1;
                                    state_d   = S_IDLE;
                                end
                            end else begin
                                unique case (1'b1)
                                    (rx_byte == CMD_CONVERT): begin
                                        conv_start = 1'b1;
                                        state_d    = S_CONV_RD;
                                    end
                                    (rx_byte == CMD_READ_SP): begin
                                        crc_clr = 1'b1;
                                        state_d = S_TX;
                                    end
                                    default: begin
                                        cmd_err_d = 1'b1;
                                        state_d   = S_IDLE;
                                    end
                                endcase
                            end
                        end
                    end
                end
                S_CONV_RD, S_TX: begin
                    if (state_q == S_TX && bit_q == 7'd72 && !slot_q) begin
                        state_d = S_IDLE;
                    end else if (slot_edge) begin
                        slot_d  = 1'b1;
                        tmr_d   = '0;
                        txb_d   = nb;
                        dq_oe_d = ~nb;
                        if (state_q == S_TX) begin
                            bit_d  = bit_q + 7'd1;
                            crc_en = ~bit_q[6];
                        end
                    end else if (slot_q) begin
                        if (tmr_q == TW'(TX0_US)) begin
                            slot_d = 1'b0;
                        end else begin
                            dq_oe_d = ~txb_q;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            slot_q    <= 1'b0;
            txb_q     <= 1'b1;
            bit_q     <= '0;
            sh_q      <= '0;
            dq_oe_q   <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            slot_q    <= slot_d;
            txb_q     <= txb_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            dq_oe_q   <= dq_oe_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Conversion survives 1-Wire resets; temp_in lands as busy drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            conv_q <= '0;
            temp_q <= TEMP_POR;
        end else if (conv_start) begin
            busy_q <= 1'b1;
            conv_q <= '0;
        end else if (busy_q && tick) begin
            if (conv_q == 20'(CONV_US - 1)) begin
                busy_q <= 1'b0;
                temp_q <= temp_in;
            end else begin
                conv_q <= conv_q + 20'd1;
            end
        end
    end

    onewire_crc8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (tx_cur),
        .crc_o (crc)
    );

    assign dq_oe     = dq_oe_q;
    assign conv_busy = busy_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_onewire_temp_slave.sv
// tb_onewire_temp_slave: directed bench acting as 1-Wire master
// against the responder on a wired-AND dq line.
`timescale 1ns/1ps
module tb_onewire_temp_slave;

    localparam int CPU  = 4;
    localparam int SLOT = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        master_low = 1'b0;
    logic [15:0] temp_in = 16'h1234;
    logic        dq_in, dq_oe, conv_busy, cmd_err;

    int n_chk = 0;
    int n_err = 0;
    int n_oe  = 0;
    int n_ce  = 0;

    typedef struct {
        logic [15:0] temp;
        bit          conv;
        logic [7:0]  exp [9];
    } vec_t;

    vec_t vecs [2];

    assign dq_in = ~(master_low | dq_oe);

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dq_oe) n_oe <= n_oe + 1;
        if (cmd_err) n_ce <= n_ce + 1;
    end

    onewire_temp_slave #(
        .CLK_PER_US (CPU),
        .CONV_US    (100),
        .SAMPLE_US  (15),
        .TX0_US     (25)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dq_in     (dq_in),
        .dq_oe     (dq_oe),
        .temp_in   (temp_in),
        .conv_busy (conv_busy),
        .cmd_err   (cmd_err)
    );

    function automatic logic [7:0] crc8_model(input logic [63:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input int act,
                             input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * CPU) @(negedge clk);
    endtask

    task automatic wr_bit(input logic b);
        master_low = 1'b1;
        wait_us(b ? 2 : 22);
        master_low = 1'b0;
        wait_us(b ? SLOT - 2 : SLOT - 22);
    endtask

    task automatic wr_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) wr_bit(v[i]);
    endtask

    task automatic rd_bit(output logic b);
        master_low = 1'b1;
        wait_us(1);
        master_low = 1'b0;
        wait_us(9);
        b = dq_in;
        wait_us(SLOT - 10);
    endtask

    task automatic rd_byte(output logic [7:0] v);
        logic b;
        for (int i = 0; i < 8; i++) begin
            rd_bit(b);
            v[i] = b;
        end
    endtask

    task automatic ow_reset(input string nm);
        int base;
        master_low = 1'b1;
        wait_us(500);
        master_low = 1'b0;
        base = n_oe;
        wait_us(160);
        check_rng(nm, n_oe - base, 119 * CPU, 121 * CPU);
    endtask

    initial begin
        int          cnt, base, base_ce, zeros;
        logic        b, got;
        logic [7:0]  by;
        logic [19:0] acc;
        logic [63:0] pk;

        vecs[0].temp = 16'h1234;
        vecs[0].conv = 1'b0;
        vecs[0].exp  = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F,
                         8'hFF, 8'h0C, 8'h10, 8'h1C};
        vecs[1].temp = 16'h0191;
        vecs[1].conv = 1'b1;
        vecs[1].exp  = '{8'h91, 8'h01, 8'h4B, 8'h46, 8'h7F,
                         8'hFF, 8'h0C, 8'h10, 8'h00};
        for (int i = 0; i < 8; i++) pk[8*i +: 8] = vecs[1].exp[i];
        vecs[1].exp[8] = crc8_model(pk);

        repeat (5) @(negedge clk);
        check("rst_dq_oe", 32'(dq_oe), 32'd0);
        check("rst_conv_busy", 32'(conv_busy), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst_n = 1'b1;
        wait_us(10);

        master_low = 1'b1;
        wait_us(300);
        master_low = 1'b0;
        base = n_oe;
        wait_us(200);
        check("short_pulse_no_pres", 32'(n_oe - base), 32'd0);

        master_low = 1'b1;
        wait_us(500);
        master_low = 1'b0;
        cnt = 0;
        while (!dq_oe && cnt < 400 * CPU) begin
            @(negedge clk);
            cnt++;
        end
        check_rng("pres_delay_cyc", cnt, 29 * CPU, 31 * CPU);
        cnt = 0;
        while (dq_oe && cnt < 400 * CPU) begin
            @(negedge clk);
            cnt++;
        end
        check_rng("pres_len_cyc", cnt, 119 * CPU, 121 * CPU);
        wait_us(20);

        for (int v = 0; v < 2; v++) begin
            temp_in = vecs[v].temp;
            if (vecs[v].conv) begin
                ow_reset("pres_conv");
                wr_byte(8'hCC);
                wr_byte(8'h44);
                check("conv_busy_set", 32'(conv_busy), 32'd1);
                zeros = 0;
                got   = 1'b0;
                for (int k = 0; k < 10 && !got; k++) begin
                    rd_bit(b);
                    if (b) got = 1'b1;
                    else zeros++;
                end
                check("conv_done_seen", 32'(got), 32'd1);
                check_rng("conv_zero_slots", zeros, 2, 4);
                check("conv_busy_clr", 32'(conv_busy), 32'd0);
            end
            ow_reset("pres_read");
            wr_byte(8'hCC);
            wr_byte(8'hBE);
            for (int i = 0; i < 9; i++) begin
                rd_byte(by);
                check($sformatf("v%0d_byte%0d", v, i), 32'(by),
                      32'(vecs[v].exp[i]));
            end
        end

        ow_reset("pres_t_err");
        base    = n_oe;
        base_ce = n_ce;
        wr_byte(8'h55);
        wait_us(50);
        for (int k = 0; k < 4; k++) rd_bit(b);
        check("err_pulses", 32'(n_ce - base_ce), 32'd1);
        check("err_no_oe", 32'(n_oe - base), 32'd0);
        ow_reset("pres_after_err");

        wr_byte(8'hCC);
        wr_byte(8'hBE);
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            rd_bit(b);
            acc[i] = b;
        end
        check("partial20", 32'(acc), 32'h000B0191);
        ow_reset("pres_abort");
        wr_byte(8'hCC);
        wr_byte(8'hBE);
        rd_byte(by);
        check("restart_byte0", 32'(by), 32'h91);
        rd_byte(by);
        check("restart_byte1", 32'(by), 32'h01);

        ow_reset("pres_t_rst");
        wr_byte(8'hCC);
        wr_byte(8'hBE);
        rd_bit(b);
        check("t_rst_bit0", 32'(b), 32'd1);
        master_low = 1'b1;
        cnt = 0;
        while (!dq_oe && cnt < 20 * CPU) begin
            @(negedge clk);
            cnt++;
        end
        check("t_rst_drive_seen", 32'(dq_oe), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t_rst_oe_release", 32'(dq_oe), 32'd0);
        wait_us(2);
        master_low = 1'b0;
        wait_us(2);
        rst_n = 1'b1;
        wait_us(20);
        ow_reset("pres_post_rst");
        wr_byte(8'hCC);
        wr_byte(8'hBE);
        rd_byte(by);
        check("post_rst_byte0", 32'(by), 32'h50);
        rd_byte(by);
        check("post_rst_byte1", 32'(by), 32'h05);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
